// File: rtl/iterative_shifter.sv
// Multi-cycle barrel-free shifter: SLL/SRL/SRA/ROTR applied one step per clock.
// Define SHIFTER_FAST4_EN to let each step move 4 bit positions while count >= 4.
module iterative_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] shamt,
    output logic [31:0] Y,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] work_q;
    logic [4:0]  count_q;
    logic [1:0]  op_q;
    logic        load;
    logic        step;
    logic        finish;
    logic        use_four;
    logic [4:0]  count_dec;
    logic [31:0] work_step;

    // The zero-extender feeds a full word; only the low five bits are a shift amount.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^shamt[31:5];

`ifdef SHIFTER_FAST4_EN
    assign use_four = (count_q >= 5'd4);
`else
    assign use_four = 1'b0;
`endif

    assign count_dec = use_four ? 5'd4 : 5'd1;

    always_comb begin
        work_step = work_q;
        case (op_q)
            OP_SLL:  work_step = use_four ? {work_q[27:0], 4'b0000}
                                          : {work_q[30:0], 1'b0};
            OP_SRL:  work_step = use_four ? {4'b0000, work_q[31:4]}
                                          : {1'b0, work_q[31:1]};
            OP_SRA:  work_step = use_four ? {{4{work_q[31]}}, work_q[31:4]}
                                          : {work_q[31], work_q[31:1]};
            OP_ROTR: work_step = use_four ? {work_q[3:0], work_q[31:4]}
                                          : {work_q[0], work_q[31:1]};
            default: work_step = work_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q != 5'd0) begin
                    step = 1'b1;
                end else begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Y is only written on the finishing edge, so it holds between operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q  <= 32'd0;
            count_q <= 5'd0;
            op_q    <= OP_SLL;
            Y       <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                work_q  <= A;
                count_q <= shamt[4:0];
                op_q    <= op;
                busy    <= 1'b1;
            end else if (step) begin
                work_q  <= work_step;
                count_q <= count_q - count_dec;
            end
            if (finish) begin
                Y    <= work_q;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed self-checking bench for iterative_shifter; expected results are hand-computed.
// Honours SHIFTER_FAST4_EN for the expected latencies.
module tb_iterative_shifter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] shamt;
    logic [31:0] Y;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    localparam int BUDGET = 64;

    iterative_shifter dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .shamt (shamt),
        .Y     (Y),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_lat(input int n);
`ifdef SHIFTER_FAST4_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    // Present a request for one edge, then scramble the inputs so the latched copy is used.
    task automatic launch(input logic [31:0] a, input logic [31:0] s, input logic [1:0] o);
        A     = a;
        shamt = s;
        op    = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = ~a;
        shamt = s ^ 32'h0000_0015;
        op    = o + 2'd1;
    endtask

    task automatic wait_done(output int cycles, output logic [31:0] y);
        cycles = 0;
        while (done !== 1'b1 && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        y = Y;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'd0;
        shamt = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (Y !== 32'd0) begin
            n_err++;
            $display("[TB] FAIL reset_Y: got %h expected %h", Y, 32'd0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        @(negedge clk);
    endtask

    task automatic test_shift_ops();
        logic [31:0] va [10];
        logic [31:0] vs [10];
        logic [1:0]  vo [10];
        logic [31:0] vy [10];
        int          cyc;
        logic [31:0] y;
        va[0] = 32'h8000_0000; vs[0] = 32'h0000_001B; vo[0] = 2'b10; vy[0] = 32'hFFFF_FFF0;
        va[1] = 32'h8000_0000; vs[1] = 32'h0000_001B; vo[1] = 2'b01; vy[1] = 32'h0000_0010;
        va[2] = 32'h0000_0001; vs[2] = 32'h0000_001F; vo[2] = 2'b00; vy[2] = 32'h8000_0000;
        va[3] = 32'h1234_5678; vs[3] = 32'h0000_0008; vo[3] = 2'b11; vy[3] = 32'h7812_3456;
        va[4] = 32'h7000_0000; vs[4] = 32'h0000_0004; vo[4] = 2'b10; vy[4] = 32'h0700_0000;
        va[5] = 32'h0000_00FF; vs[5] = 32'h0000_0005; vo[5] = 2'b00; vy[5] = 32'h0000_1FE0;
        va[6] = 32'hFFFF_FFFF; vs[6] = 32'h0000_0007; vo[6] = 2'b01; vy[6] = 32'h01FF_FFFF;
        va[7] = 32'h0000_000F; vs[7] = 32'h0000_0004; vo[7] = 2'b11; vy[7] = 32'hF000_0000;
        va[8] = 32'h8000_0000; vs[8] = 32'h0000_001F; vo[8] = 2'b10; vy[8] = 32'hFFFF_FFFF;
        va[9] = 32'hF000_0000; vs[9] = 32'h0000_0006; vo[9] = 2'b10; vy[9] = 32'hFFC0_0000;
        for (int i = 0; i < 10; i++) begin
            launch(va[i], vs[i], vo[i]);
            wait_done(cyc, y);
            n_cmp++;
            if (y !== vy[i]) begin
                n_err++;
                $display("[TB] FAIL op%0d_Y: got %h expected %h", i, y, vy[i]);
            end
            n_cmp++;
            if (cyc != exp_lat(int'(vs[i][4:0]))) begin
                n_err++;
                $display("[TB] FAIL op%0d_latency: got %0d expected %0d", i, cyc,
                         exp_lat(int'(vs[i][4:0])));
            end
            @(negedge clk);
        end
        // Sign-fill case with its latency fixed by hand for each build.
        launch(32'h8000_0000, 32'h0000_001B, 2'b10);
        wait_done(cyc, y);
        n_cmp++;
`ifdef SHIFTER_FAST4_EN
        if (cyc != 10) begin
`else
        if (cyc != 28) begin
`endif
            n_err++;
            $display("[TB] FAIL sra27_latency: got %0d", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_shift();
        for (int o = 0; o < 4; o++) begin
            launch(32'h1234_5678, 32'h0000_0000, 2'(o));
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL zero_op%0d_busy: got busy=%b done=%b expected busy=1 done=0",
                         o, busy, done);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL zero_op%0d_done: got busy=%b done=%b expected busy=0 done=1",
                         o, busy, done);
            end
            n_cmp++;
            if (Y !== 32'h1234_5678) begin
                n_err++;
                $display("[TB] FAIL zero_op%0d_Y: got %h expected %h", o, Y, 32'h1234_5678);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_upper_shamt();
        int          cyc;
        logic [31:0] y;
        launch(32'h0000_0001, 32'h0000_0021, 2'b11);
        wait_done(cyc, y);
        n_cmp++;
        if (y !== 32'h8000_0000) begin
            n_err++;
            $display("[TB] FAIL upper_shamt_Y: got %h expected %h", y, 32'h8000_0000);
        end
        n_cmp++;
        if (cyc != 2) begin
            n_err++;
            $display("[TB] FAIL upper_shamt_latency: got %0d expected 2", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int          ndone = 0;
        int          dcyc  = -1;
        logic [31:0] y     = 32'd0;
        launch(32'hF000_0000, 32'd10, 2'b01);
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                A     = 32'hFFFF_FFFF;
                shamt = 32'd1;
                op    = 2'b00;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                dcyc = c;
                y    = Y;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (ndone != 1) begin
            n_err++;
            $display("[TB] FAIL busy_ignore_count: got %0d done pulses expected 1", ndone);
        end
        n_cmp++;
        if (y !== 32'h003C_0000) begin
            n_err++;
            $display("[TB] FAIL busy_ignore_Y: got %h expected %h", y, 32'h003C_0000);
        end
        n_cmp++;
        if (dcyc != exp_lat(10)) begin
            n_err++;
            $display("[TB] FAIL busy_ignore_latency: got %0d expected %0d", dcyc, exp_lat(10));
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        logic [31:0] y;
        launch(32'h0000_0001, 32'd3, 2'b00);
        wait_done(cyc, y);
        n_cmp++;
        if (y !== 32'h0000_0008) begin
            n_err++;
            $display("[TB] FAIL b2b_first_Y: got %h expected %h", y, 32'h0000_0008);
        end
        launch(32'h0000_0002, 32'd1, 2'b11);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        n_cmp++;
        if (Y !== 32'h0000_0008) begin
            n_err++;
            $display("[TB] FAIL b2b_Y_hold: got %h expected %h", Y, 32'h0000_0008);
        end
        wait_done(cyc, y);
        n_cmp++;
        if (y !== 32'h0000_0001 || cyc != 2) begin
            n_err++;
            $display("[TB] FAIL b2b_second: got Y=%h after %0d expected Y=00000001 after 2", y, cyc);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || Y !== 32'h0000_0001) begin
            n_err++;
            $display("[TB] FAIL b2b_pulse_end: got done=%b Y=%h expected done=0 Y=00000001", done, Y);
        end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        launch(32'h0000_0001, 32'd20, 2'b00);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || Y !== 32'd0) begin
            n_err++;
            $display("[TB] FAIL abort_state: got busy=%b done=%b Y=%h expected 0 0 00000000",
                     busy, done, Y);
        end
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_err++;
            $display("[TB] FAIL abort_no_done: got %0d done pulses expected 0", ndone);
        end
        // Reset wins over a simultaneous start.
        A     = 32'h0000_00F0;
        shamt = 32'd2;
        op    = 2'b01;
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_over_start: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_shift_ops();
        test_zero_shift();
        test_upper_shamt();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
